// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for the digit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_add_slice.sv
// rtl/serial_adder_add_slice.sv - combinational DIGIT-bit ripple slice with carry into its MSB
module serial_adder_add_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit with valid/ready on both sides
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEP  = WIDTH / DIGIT;
  localparam int STEP_W = clog2_min1(NSTEP);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  a_r, b_r, acc_r, acc_nxt;
  logic              carry_r;
  logic [DIGIT-1:0]  dig_s;
  logic              sl_cout, sl_cmsb;
  logic              last_step;

  // Operands shift right each step so the slice always sees the low digit.
  serial_adder_add_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_r[DIGIT-1:0]),
    .b     (b_r[DIGIT-1:0]),
    .cin   (carry_r),
    .s     (dig_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  assign last_step = (step == LAST_STEP);
  assign acc_nxt   = (acc_r >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // The working accumulator is separate from sum so the last result stays visible until the next op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      step    <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            step    <= '0;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          acc_r   <= acc_nxt;
          carry_r <= sl_cout;
          step    <= step + STEP_W'(1);
          if (last_step) begin
            sum  <= acc_nxt;
            cout <= sl_cout;
            ovf  <= sl_cout ^ sl_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and exhaustive checks of serial_adder against an arithmetic model
module tb_serial_adder;

  logic        clk;
  logic        rst_n     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] a         [3];
  logic [15:0] b         [3];
  logic        cin       [3];
  logic        sub       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] sum       [3];
  logic        cout      [3];
  logic        ovf       [3];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][3:0]), .b(b[1][3:0]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1][3:0]), .cout(cout[1]), .ovf(ovf[1])
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][3:0]), .b(b[2][3:0]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum[2][3:0]), .cout(cout[2]), .ovf(ovf[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Result from plain integer arithmetic: {ovf, cout, sum}; ovf means the signed sum left the w-bit range.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] av_i, input logic [15:0] bv_i,
                                          input logic cin_i, input logic sub_i);
    longint m, av, bv, c, full, half, sa, sb, s;
    logic o, co;
    m    = (longint'(1) << w) - 1;
    av   = longint'(av_i) & m;
    bv   = sub_i ? ((~longint'(bv_i)) & m) : (longint'(bv_i) & m);
    c    = sub_i ? 1 : longint'(cin_i);
    full = av + bv + c;
    half = longint'(1) << (w - 1);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    s    = sa + sb + c;
    o    = (s >= half) || (s < -half);
    co   = ((full >> w) & 1) != 0;
    return {o, co, 16'(full & m)};
  endfunction

  // Per-instance model: accept, count NSTEP edges, hold result until taken.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int W  = (g == 0) ? 16 : 4;
    localparam int NS = (g == 2) ? 1 : 4;
    localparam logic [15:0] MASK = 16'((32'd1 << W) - 1);
    int          mst = 0;
    int          cnt = 0;
    logic [17:0] expv = '0;
    logic [17:0] lastv = '0;

    always @(posedge clk) begin
      if (!rst_n[g]) begin
        mst   = 0;
        lastv = '0;
      end else begin
        case (mst)
          0: if (in_valid[g]) begin
               expv = ref_add(W, a[g], b[g], cin[g], sub[g]);
               cnt  = NS;
               mst  = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 mst   = 2;
                 lastv = expv;
               end
             end
          default: if (out_ready[g]) mst = 0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (!rst_n[g]) begin
        chk($sformatf("u%0d_rst_in_ready", g),  32'(in_ready[g]),  32'd1);
        chk($sformatf("u%0d_rst_out_valid", g), 32'(out_valid[g]), 32'd0);
        chk($sformatf("u%0d_rst_sum", g),       32'(sum[g] & MASK), 32'd0);
        chk($sformatf("u%0d_rst_cout_ovf", g),  {30'd0, cout[g], ovf[g]}, 32'd0);
      end else begin
        chk($sformatf("u%0d_in_ready", g),  32'(in_ready[g]),  32'(mst == 0));
        chk($sformatf("u%0d_out_valid", g), 32'(out_valid[g]), 32'(mst == 2));
        chk($sformatf("u%0d_sum", g),       32'(sum[g] & MASK), 32'(lastv[15:0]));
        chk($sformatf("u%0d_cout", g),      32'(cout[g]), 32'(lastv[16]));
        chk($sformatf("u%0d_ovf", g),       32'(ovf[g]),  32'(lastv[17]));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input bit rnd);
    int n;
    n = 0;
    while (!in_ready[i] && n < 200) begin
      if (rnd) out_ready[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk($sformatf("u%0d_wait_in_ready_timeout", i), 32'(n), 32'd0);
    if (rnd) out_ready[i] = ($urandom_range(0, 3) != 0);
    a[i] = av; b[i] = bv; cin[i] = ci; sub[i] = sb;
    in_valid[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    a[i] = 16'($urandom);
    b[i] = 16'($urandom);
  endtask

  task automatic op_dir(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n;
    drive_op(0, av, bv, ci, sb, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_sum"},  32'(sum[0]),  32'(es));
    chk({nm, "_cout"}, 32'(cout[0]), 32'(ec));
    chk({nm, "_ovf"},  32'(ovf[0]),  32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic flush(input int i);
    int n;
    out_ready[i] = 1'b1;
    n = 0;
    while (!in_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d_flush", i), 32'(in_ready[i]), 32'd1);
  endtask

  task automatic exhaustive(input int i);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int k = 0; k < 4; k++)
          drive_op(i, 16'(x), 16'(y), k[0], k[1], 1'b1);
    flush(i);
  endtask

  task automatic inst0_seq();
    chk("model_pin_add", 32'(ref_add(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h2_8000);
    chk("model_pin_sub", 32'(ref_add(16, 16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h3_7FFF);
    chk("model_pin_w4",  32'(ref_add(4, 16'h0007, 16'h0001, 1'b1, 1'b0)), 32'h2_0009);

    op_dir("add_wrap", 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_dir("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op_dir("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_dir("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-pressure: result must hold while in_valid pulses are ignored.
    out_ready[0] = 1'b0;
    drive_op(0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("hold_out_valid_start", 32'(out_valid[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = ~in_valid[0];
      a[0] = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
    chk("hold_sum", {15'd0, ovf[0], cout[0], sum[0]}, 32'h1_0000);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;

    // Reset after the second RUN edge discards the op.
    drive_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_outputs", {28'd0, in_ready[0], out_valid[0], cout[0], ovf[0]}, 32'h8);
    chk("mid_rst_sum", 32'(sum[0]), 32'd0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    op_dir("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    for (int k = 0; k < 150; k++)
      drive_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    flush(0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      a[i] = '0; b[i] = '0; cin[i] = 1'b0; sub[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    fork
      inst0_seq();
      exhaustive(1);
      exhaustive(2);
    join
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
